// File: rtl/coin_render.sv
// coin_render: the player square moves one step per frame. A coin waits at a
// position chosen by an LFSR. Touching the coin adds one to the score and
// starts a respawn.
// Each pixel gets its colour one cycle after its counters arrive. The syncs
// are delayed by the same cycle so that they stay aligned with RGB.
//
// Ports
//   pixClk            pixel clock (only clock)
//   rst               synchronous active-high reset
//   horiz_counter     current pixel column (11 bits)
//   vert_counter      current line (10 bits)
//   video             1 = visible region
//   horiz_sync_pulse  hsync from the timing core
//   vert_sync_pulse   vsync from the timing core
//   btn               {up, down, left, right}, 1 = pressed
//   red/green/blue    registered 4-bit colour
//   hsync_out         horiz_sync_pulse delayed one cycle
//   vsync_out         vert_sync_pulse delayed one cycle
//   score             coins collected, saturates at 255
//
// state   | meaning
// PLAY    | coin is visible; overlap is checked after each position update
// COLLECT | one cycle that bumps the score
// RESPAWN | try one LFSR candidate per cycle until a legal one is found

module coin_render #(
    parameter int hDisp = 640,
    parameter int vDisp = 480,
    parameter int PSIZE = 16,
    parameter int CSIZE = 8,
    parameter int STEP  = 2
) (
    input  logic        pixClk,
    input  logic        rst,
    input  logic [10:0] horiz_counter,
    input  logic [9:0]  vert_counter,
    input  logic        video,
    input  logic        horiz_sync_pulse,
    input  logic        vert_sync_pulse,
    input  logic [3:0]  btn,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic [7:0]  score
);

    localparam logic [9:0] PX_MAX = 10'(hDisp - PSIZE);
    localparam logic [8:0] PY_MAX = 9'(vDisp - PSIZE);
    localparam logic [9:0] CX_MAX = 10'(hDisp - CSIZE);
    localparam logic [8:0] CY_MAX = 9'(vDisp - CSIZE);

    typedef enum logic [1:0] {PLAY, COLLECT, RESPAWN} state_t;

    state_t      state, state_next;
    logic [9:0]  px, cx, px_next, cand_x;
    logic [8:0]  py, cy, py_next, cand_y;
    logic [15:0] lfsr;
    logic        pos_upd, frame_tick, cand_ok, load_coin, score_inc;
    logic        in_player, in_coin;
    logic [10:0] px_inc;
    logic [9:0]  py_inc;

    // Player/coin overlap. The values are widened so that pos+size cannot wrap.
    function automatic logic hits(input logic [9:0] pxv, input logic [8:0] pyv,
                                  input logic [9:0] cxv, input logic [8:0] cyv);
        return ({1'b0, pxv} < {1'b0, cxv} + 11'(CSIZE)) &&
               ({1'b0, cxv} < {1'b0, pxv} + 11'(PSIZE)) &&
               ({1'b0, pyv} < {1'b0, cyv} + 10'(CSIZE)) &&
               ({1'b0, cyv} < {1'b0, pyv} + 10'(PSIZE));
    endfunction

    assign frame_tick = (horiz_counter == 11'd0) && (vert_counter == 10'(vDisp));

    // If both buttons of an axis are pressed, that axis holds.
    // The subtract path tests for underflow before it subtracts.
    always_comb begin
        px_inc  = {1'b0, px} + 11'(STEP);
        py_inc  = {1'b0, py} + 10'(STEP);
        px_next = px;
        py_next = py;
        if (btn[0] && !btn[1])
            px_next = (px_inc > {1'b0, PX_MAX}) ? PX_MAX : px_inc[9:0];
        else if (btn[1] && !btn[0])
            px_next = (px < 10'(STEP)) ? 10'd0 : px - 10'(STEP);
        if (btn[2] && !btn[3])
            py_next = (py_inc > {1'b0, PY_MAX}) ? PY_MAX : py_inc[8:0];
        else if (btn[3] && !btn[2])
            py_next = (py < 9'(STEP)) ? 9'd0 : py - 9'(STEP);
    end

    assign cand_x  = lfsr[9:0];
    assign cand_y  = lfsr[8:0];
    assign cand_ok = (cand_x <= CX_MAX) && (cand_y <= CY_MAX) &&
                     !hits(px, py, cand_x, cand_y);

    always_comb begin
        state_next = state;
        load_coin  = 1'b0;
        score_inc  = 1'b0;
        case (state)
            PLAY:    if (pos_upd && hits(px, py, cx, cy)) state_next = COLLECT;
            COLLECT: begin
                score_inc  = 1'b1;
                state_next = RESPAWN;
            end
            RESPAWN: if (cand_ok) begin
                load_coin  = 1'b1;
                state_next = PLAY;
            end
            default: state_next = PLAY;
        endcase
    end

    assign in_player = ({1'b0, px} <= horiz_counter) &&
                       (horiz_counter < {1'b0, px} + 11'(PSIZE)) &&
                       ({1'b0, py} <= vert_counter) &&
                       (vert_counter < {1'b0, py} + 10'(PSIZE));
    assign in_coin   = (state == PLAY) &&
                       ({1'b0, cx} <= horiz_counter) &&
                       (horiz_counter < {1'b0, cx} + 11'(CSIZE)) &&
                       ({1'b0, cy} <= vert_counter) &&
                       (vert_counter < {1'b0, cy} + 10'(CSIZE));

    always_ff @(posedge pixClk) begin
        if (rst) begin
            state     <= PLAY;
            px        <= 10'd312;
            py        <= 9'd232;
            cx        <= 10'd100;
            cy        <= 9'd100;
            lfsr      <= 16'hACE1;
            pos_upd   <= 1'b0;
            score     <= 8'd0;
            red       <= 4'h0;
            green     <= 4'h0;
            blue      <= 4'h0;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
        end else begin
            state   <= state_next;
            lfsr    <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            pos_upd <= frame_tick;
            if (frame_tick) begin
                px <= px_next;
                py <= py_next;
            end
            if (score_inc && score != 8'hFF) score <= score + 8'd1;
            if (load_coin) begin
                cx <= cand_x;
                cy <= cand_y;
            end
            hsync_out <= horiz_sync_pulse;
            vsync_out <= vert_sync_pulse;
            if (!video)         {red, green, blue} <= 12'h000;
            else if (in_player) {red, green, blue} <= 12'h0F0;
            else if (in_coin)   {red, green, blue} <= 12'hFF0;
            else                {red, green, blue} <= 12'h004;
        end
    end

endmodule

// File: doc/coin_render.md
COIN_RENDER -- requirements
Module: coin_render

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
- hDisp, 640, visible pixels per line
- vDisp, 480, visible lines per frame
- PSIZE, 16, player square side in pixels
- CSIZE, 8, coin square side in pixels
- STEP, 2, player move per frame, in pixels

REQ-002 SHALL have ports (name, direction, width, meaning), one per line:
- pixClk, in, 1, pixel clock; the only clock
- rst, in, 1, synchronous, active-high reset
- horiz_counter, in, 11, current pixel column from timing core
- vert_counter, in, 10, current line from timing core
- video, in, 1, 1 = visible region
- horiz_sync_pulse, in, 1, hsync from timing core
- vert_sync_pulse, in, 1, vsync from timing core
- btn, in, 4, {up, down, left, right}; 1 = pressed; already synchronous to pixClk
- red, out, 4, pixel red
- green, out, 4, pixel green
- blue, out, 4, pixel blue
- hsync_out, out, 1, horiz_sync_pulse delayed to match RGB
- vsync_out, out, 1, vert_sync_pulse delayed to match RGB
- score, out, 8, coins collected

REQ-003 SHALL use one clock, pixClk, with reset synchronous and active-high on rst; all state SHALL update on the rising pixClk edge.

Function
REQ-004 SHALL raise an internal one-cycle frame tick in the cycle where horiz_counter==0 and vert_counter==vDisp.

REQ-005 Player position SHALL be held as px (10 bits) and py (9 bits); both SHALL change only in the cycle after a frame tick.

REQ-006 On a frame tick:
- px SHALL move +STEP for right and -STEP for left.
- py SHALL move -STEP for up and +STEP for down.
- If both buttons of an axis are pressed, that axis SHALL NOT move.

REQ-007 Movement SHALL clamp px to 0..hDisp-PSIZE and py to 0..vDisp-PSIZE, with no wrap-around and no underflow.

REQ-008 A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 0xACE1) SHALL advance every cycle and never reach zero.

REQ-009 The controller SHALL be an FSM with states PLAY, COLLECT, RESPAWN.

REQ-010 PLAY -> COLLECT in the cycle after a position update, if the player and coin overlap.
- Overlap: px < cx+CSIZE and cx < px+PSIZE, and likewise on the y axis.

REQ-011 COLLECT SHALL increment score by 1, saturating at 255, then go to RESPAWN after exactly one cycle.

REQ-012 RESPAWN SHALL each cycle form a candidate cx=lfsr[9:0], cy=lfsr[8:0] and accept it only if all hold:
- cx<=hDisp-CSIZE
- cy<=vDisp-CSIZE
- the candidate does not overlap the player

On acceptance the FSM SHALL load cx/cy and go to PLAY; otherwise it SHALL stay in RESPAWN.

REQ-013 The coin SHALL be drawn only in PLAY.

REQ-014 Render path SHALL have 1-cycle latency. RGB SHALL be registered from the same-cycle horiz_counter, vert_counter and video, with colours by priority:
- video==0: 0,0,0
- player pixel: 0,F,0
- coin pixel: F,F,0
- otherwise: 0,0,4

REQ-015 hsync_out and vsync_out SHALL be registered copies of their inputs, aligned with RGB.

REQ-016 The player pixel test SHALL be px<=hc<px+PSIZE and py<=vc<py+PSIZE; the coin pixel test SHALL be the same using cx, cy and CSIZE.

Reset
REQ-017 With rst high at a pixClk edge, the following SHALL take effect at that edge:
- RGB=0
- score=0
- px=312, py=232
- cx=100, cy=100
- FSM=PLAY
- LFSR=0xACE1
- hsync_out=1, vsync_out=1

REQ-018 Reset asserted mid-COLLECT or mid-RESPAWN SHALL abort without a score change.

REQ-019 After rst falls, the first output pixel SHALL be valid one cycle later.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset held 2 cycles -> score=0, px=312, py=232, RGB=0, syncs=1, FSM=PLAY.
- right held for 5 frame ticks -> px=322; left held from px=2 for 3 ticks -> px=0 and stays 0.
- Both left and right held for 4 ticks -> px unchanged; up held from py=0 -> py stays 0.
- hc=312, vc=232, video=1 -> next cycle RGB=0,F,0; hc=100, vc=100 -> F,F,0; video=0 -> 0,0,0.
- Player steered onto the coin -> score 0->1; new cx<=632, cy<=472; no overlap with player; FSM returns to PLAY.
- 256 forced collections -> score saturates at 255; rst during RESPAWN -> coin restored to 100,100.
